// File: rtl/fp_acc_pkg.sv
// Shared definitions for fp_stream_accumulator: FSM state encoding, FP field
// widths per format and the FP zero constant.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  // IEEE-754 binary16 / binary32 / binary64 exponent field width
  function automatic int fp_exp_width(input int dw);
    case (dw)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int fp_man_width(input int dw);
    return dw - 1 - fp_exp_width(dw);
  endfunction

  localparam logic [63:0] FP_ZERO = '0;

endpackage

// File: rtl/fp_stream_accumulator_floatadd.sv
// floatAdd: combinational IEEE-754 adder (round-to-nearest-even, subnormals,
// inf/NaN propagation) for 16, 32 or 64-bit formats.
module floatAdd
  import fp_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam int EW = fp_exp_width(DATA_WIDTH);
  localparam int MW = fp_man_width(DATA_WIDTH);
  // carry + hidden bit + fraction + guard/round/sticky
  localparam int SW = MW + 5;
  localparam logic [EW-1:0] EMAX  = '1;
  localparam logic [EW:0]   E_ONE = (EW+1)'(1);

  logic            swap, sx, sy, sub, rnd, nan;
  logic [EW-1:0]   ex, ey;
  logic [MW-1:0]   fx, fy;
  logic [EW:0]     e, d;
  logic [SW-1:0]   mx, my, m;
  logic [MW+1:0]   mr;

  always_comb begin
    swap = b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
    {sx, ex, fx} = swap ? b : a;
    {sy, ey, fy} = swap ? a : b;
    sub = sx ^ sy;

    e  = (ex == '0) ? E_ONE : {1'b0, ex};
    d  = e - ((ey == '0) ? E_ONE : {1'b0, ey});
    mx = {1'b0, ex != '0, fx, 3'b000};
    my = {1'b0, ey != '0, fy, 3'b000};

    // align smaller operand; shifted-out bits collapse into the sticky bit
    for (int unsigned i = 0; i < SW; i++)
      if (i < 32'(d)) my = {1'b0, my[SW-1:2], my[1] | my[0]};

    m = sub ? mx - my : mx + my;

    if (m[SW-1]) begin
      m = {1'b0, m[SW-1:2], m[1] | m[0]};
      e = e + E_ONE;
    end else begin
      for (int unsigned i = 0; i < SW; i++)
        if (!m[SW-2] && e > E_ONE) begin
          m = m << 1;
          e = e - E_ONE;
        end
    end

    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[SW-2:3]} + {{(MW+1){1'b0}}, rnd};
    if (mr[MW+1]) begin
      mr = mr >> 1;
      e  = e + E_ONE;
    end

    nan = (ex == EMAX && fx != '0) || (ey == EMAX && fy != '0) ||
          (ex == EMAX && ey == EMAX && sub);

    if (nan)
      sum = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
    else if (ex == EMAX)
      sum = {sx, EMAX, {MW{1'b0}}};
    else if (m == '0)
      sum = {sx & sy, {(DATA_WIDTH-1){1'b0}}};
    else if (e >= {1'b0, EMAX})
      sum = {sx, EMAX, {MW{1'b0}}};
    else if (!mr[MW])
      sum = {sx, {EW{1'b0}}, mr[MW-1:0]};
    else
      sum = {sx, e[EW-1:0], mr[MW-1:0]};
  end

endmodule

// File: rtl/fp_stream_accumulator.sv
// Accumulates a valid/ready stream of FP terms into one sum per window.
// Optional FP_ACC_BIAS_EN adds a bias port that seeds each window sum.
module fp_stream_accumulator
  import fp_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 256,
  parameter int CNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
`ifdef FP_ACC_BIAS_EN
  input  logic [DATA_WIDTH-1:0] bias,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_trunc
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LEN);

  acc_state_t            state;
  logic [DATA_WIDTH-1:0] acc, a_op, sum_c;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic                  at_max, take;

  always_comb begin
    in_ready = (state != HOLD);
    take     = in_valid && in_ready;
    cnt_next = cnt + CNT_WIDTH'(1);
    at_max   = (cnt_next == MAX_CNT);
`ifdef FP_ACC_BIAS_EN
    a_op     = (state == IDLE) ? bias : acc;
`else
    a_op     = (state == IDLE) ? FP_ZERO[DATA_WIDTH-1:0] : acc;
`endif
  end

  floatAdd #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a   (a_op),
    .b   (in_data),
    .sum (sum_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        // cnt is 0 in IDLE, so cnt_next covers both the first and later beats
        IDLE, ACC: begin
          if (take) begin
            acc <= sum_c;
            cnt <= cnt_next;
            if (in_last || at_max) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= sum_c;
              out_count <= cnt_next;
              out_trunc <= at_max && !in_last;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Scoreboard bench for fp_stream_accumulator (DATA_WIDTH=32, MAX_LEN=4);
// terms are exact multiples of 0.5 so window sums are modelled with integers.
module tb_fp_stream_accumulator;

  localparam int MAXL = 4;
  localparam int CW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  always #5 clk = ~clk;

  fp_stream_accumulator #(.DATA_WIDTH(32), .MAX_LEN(MAXL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  typedef struct {
    logic [31:0] data;
    int          count;
    bit          trunc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  int          m_sum    = 0;
  int          m_cnt    = 0;
  int          rdy_mode = 1;
  bit          mon_en   = 1'b0;
  logic [31:0] last_data;
  int          last_count;
  bit          last_trunc;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endfunction

  // value is h * 0.5; |h| < 2^24 so the encoding is exact
  function automatic logic [31:0] to_fp32(input int h);
    int unsigned mag;
    int          p;
    logic [31:0] r;
    if (h == 0) return 32'h0;
    mag = (h < 0) ? -h : h;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    r[31]    = (h < 0);
    r[30:23] = 8'(p + 126);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(9) < 7);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every output handshake
  initial begin
    exp_t        e;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [CW-1:0] prev_count;
    logic        prev_trunc;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        check("in_ready_vs_pending", in_ready, !out_valid);
        if (prev_hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_count", out_count, prev_count);
          check("hold_trunc", out_trunc, prev_trunc);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_count", out_count, e.count);
            check("out_trunc", out_trunc, e.trunc);
          end
          n_out++;
          last_data  = out_data;
          last_count = out_count;
          last_trunc = out_trunc;
        end
        prev_hold  = out_valid && !out_ready;
        prev_data  = out_data;
        prev_count = out_count;
        prev_trunc = out_trunc;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // called at posedge+1; returns at posedge+1
  task automatic drive_term(input logic [31:0] bits, input int h, input bit last);
    bit   done = 1'b0;
    logic ok;
    exp_t e;
    in_valid = 1'b1;
    in_data  = bits;
    in_last  = last;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL in_handshake_timeout: got no in_ready, required acceptance of %0h", bits);
      return;
    end
    m_sum += h;
    m_cnt++;
    if (last || m_cnt == MAXL) begin
      e.data  = to_fp32(m_sum);
      e.count = m_cnt;
      e.trunc = !last;
      exp_q.push_back(e);
      m_sum = 0;
      m_cnt = 0;
      @(negedge clk);
      check("latency_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out(input int target);
    for (int c = 0; c < 200 && n_out < target; c++) begin
      @(posedge clk);
      #1;
    end
    if (n_out < target) begin
      n_checks++;
      $display("FAIL wait_out: got %0d outputs, required %0d", n_out, target);
    end
  endtask

  initial begin
    int          base;
    int          len;
    int          r;
    int          h;
    logic [31:0] bits;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_trunc", out_trunc, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1.0 + 2.0
    base = n_out;
    drive_term(32'h3F80_0000, 2, 1'b0);
    drive_term(32'h4000_0000, 4, 1'b1);
    wait_out(base + 1);
    check("dir_sum3_data", last_data, 32'h4040_0000);
    check("dir_sum3_count", last_count, 2);
    check("dir_sum3_trunc", last_trunc, 0);

    // single-term window
    base = n_out;
    drive_term(32'h3F00_0000, 1, 1'b1);
    wait_out(base + 1);
    check("dir_single_data", last_data, 32'h3F00_0000);
    check("dir_single_count", last_count, 1);

    // 3.0 + -1.0 held by downstream for 5 cycles
    base = n_out;
    rdy_mode = 2;
    drive_term(32'h4040_0000, 6, 1'b0);
    drive_term(32'hBF80_0000, -2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 32'h4000_0000);
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    wait_out(base + 1);
    check("dir_sub_data", last_data, 32'h4000_0000);

    // five 1.0 terms with no last: force-close at MAX_LEN
    base = n_out;
    for (int i = 0; i < 5; i++) drive_term(32'h3F80_0000, 2, 1'b0);
    wait_out(base + 1);
    check("dir_trunc_data", last_data, 32'h4080_0000);
    check("dir_trunc_count", last_count, 4);
    check("dir_trunc_trunc", last_trunc, 1);
    drive_term(32'h3F80_0000, 2, 1'b1);
    wait_out(base + 2);
    check("dir_after_trunc_count", last_count, 2);
    check("dir_after_trunc_data", last_data, 32'h4000_0000);

    // in_last on the MAX_LEN-th term is not a truncation
    base = n_out;
    for (int i = 0; i < 4; i++) drive_term(32'h3F80_0000, 2, i == 3);
    wait_out(base + 1);
    check("dir_last_at_max_count", last_count, 4);
    check("dir_last_at_max_trunc", last_trunc, 0);

    // reset in the middle of a window discards it
    base = n_out;
    drive_term(32'h3F80_0000, 2, 1'b0);
    drive_term(32'h3F80_0000, 2, 1'b0);
    rst_n = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_term(32'h3FC0_0000, 3, 1'b1);
    wait_out(base + 1);
    check("dir_abort_data", last_data, 32'h3FC0_0000);
    check("dir_abort_count", last_count, 1);
    idle(5);
    check("dir_abort_out_beats", n_out, base + 1);

    // randomized windows, signed zeros and backpressure
    rdy_mode = 0;
    for (int w = 0; w < 80; w++) begin
      len = $urandom_range(1, 6);
      for (int t = 0; t < len; t++) begin
        r = $urandom_range(7);
        if (r == 0) begin
          h = 0;
          bits = 32'h8000_0000;
        end else if (r == 1) begin
          h = 0;
          bits = 32'h0;
        end else begin
          h = int'($urandom_range(4000)) - 2000;
          bits = to_fp32(h);
        end
        drive_term(bits, h, t == len - 1);
        idle($urandom_range(2));
      end
    end
    // flush any window left open by a trailing truncation split
    if (m_cnt != 0) drive_term(32'h0, 0, 1'b1);

    rdy_mode = 1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
